// File: rtl/measure_arbiter_pkg.sv
// Shared constants for the measureClifford round-robin arbiter.
// Holds the FSM state encodings and the default qubit count.
// No logic; imported by the interface, picker and top.
`ifndef NUM_TOTAL_QUBITS
`define NUM_TOTAL_QUBITS 4
`endif

package measure_arbiter_pkg;

   localparam int NQ_DEFAULT = `NUM_TOTAL_QUBITS;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_SETUP = 2'd1;
   localparam state_t S_HOLD  = 2'd2;
   localparam state_t S_BACK  = 2'd3;

endpackage

// File: rtl/measure_arbiter_if.sv
// Bundle of requester-side and unit-side signals around the arbiter.
// Pure wiring, no latency.
// Requesters hold setup/back_setup until they see their ready bit.
interface measure_arbiter_if
   import measure_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BASIS_W = 2 * NQ_DEFAULT,
   parameter int VALUE_W = $clog2(NQ_DEFAULT) + 1
);
   // requester side
   logic [NUM_REQ-1:0]         req_setup;
   logic [NUM_REQ-1:0]         req_back_setup;
   logic [NUM_REQ*BASIS_W-1:0] req_basis;
   logic [NUM_REQ*BASIS_W-1:0] req_result;
   logic [NUM_REQ-1:0]         req_ready;
   logic [VALUE_W-1:0]         value;
   logic                       is_zero;
   logic                       is_neg;
   logic [NUM_REQ-1:0]         grant;
   logic                       timeout;
   // unit side
   logic                       mc_setup;
   logic                       mc_back_setup;
   logic [BASIS_W-1:0]         mc_basis;
   logic [BASIS_W-1:0]         mc_result;
   logic [VALUE_W-1:0]         mc_value;
   logic                       mc_is_zero;
   logic                       mc_is_neg;
   logic                       mc_ready;

   modport master (
      input  req_setup, req_back_setup, req_basis, req_result,
      input  mc_value, mc_is_zero, mc_is_neg, mc_ready,
      output req_ready, value, is_zero, is_neg, grant, timeout,
      output mc_setup, mc_back_setup, mc_basis, mc_result
   );

   modport slave (
      output req_setup, req_back_setup, req_basis, req_result,
      output mc_value, mc_is_zero, mc_is_neg, mc_ready,
      input  req_ready, value, is_zero, is_neg, grant, timeout,
      input  mc_setup, mc_back_setup, mc_basis, mc_result
   );

endinterface

// File: rtl/measure_arbiter_rr_picker.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping.
// Combinational, zero latency.
// No backpressure; vld low when no request is set.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               vld
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0] cand;

   // walk offsets from farthest to nearest so the nearest hit to ptr wins
   always_comb begin
      vld  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (cand >= N_W) cand = cand - N_W;
         if (req[cand[IDX_W-1:0]]) begin
            vld = 1'b1;
            idx = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/measure_arbiter.sv
// Locks one measureClifford unit to a requester for setup + optional measure phase.
// Grant 1 cycle after request; ready/value/flags pass through combinationally.
// Unit's ready is the only backpressure; HOLD is bounded by a TIMEOUT watchdog.
module measure_arbiter
   import measure_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NQ      = NQ_DEFAULT,
   parameter int BASIS_W = 2 * NQ,
   parameter int VALUE_W = $clog2(NQ) + 1,
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              rst_n,
   measure_arbiter_if.master bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   state_t             state;
   logic [IDX_W-1:0]   gidx;
   logic [IDX_W-1:0]   ptr;
   logic [WD_W-1:0]    wdog;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [IDX_W-1:0]   next_ptr;
   logic [NUM_REQ-1:0] gr_oh;
   logic               phase_act;

   function automatic logic [BASIS_W-1:0] sel_vec(
      input logic [NUM_REQ*BASIS_W-1:0] v,
      input logic [IDX_W-1:0]           sel
   );
      sel_vec = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (sel == IDX_W'(k)) sel_vec = v[k*BASIS_W +: BASIS_W];
   endfunction

   rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req (bus.req_setup),
      .ptr (ptr),
      .idx (pick_idx),
      .vld (pick_vld)
   );

   assign next_ptr  = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
   assign gr_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx;
   assign phase_act = (state == S_SETUP) || (state == S_BACK);

   // owner-facing outputs decode from the registered state; response path stays combinational
   always_comb begin
      bus.grant         = (state != S_IDLE) ? gr_oh : '0;
      bus.req_ready     = (phase_act && bus.mc_ready) ? gr_oh : '0;
      bus.mc_setup      = (state == S_SETUP);
      bus.mc_back_setup = (state == S_BACK);
      bus.value         = bus.mc_value;
      bus.is_zero       = bus.mc_is_zero;
      bus.is_neg        = bus.mc_is_neg;
   end

   // transaction FSM: arbitrate, setup, hold with watchdog, measure, release
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         gidx          <= '0;
         ptr           <= '0;
         wdog          <= '0;
         bus.mc_basis  <= '0;
         bus.mc_result <= '0;
         bus.timeout   <= 1'b0;
      end else begin
         bus.timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  gidx          <= pick_idx;
                  bus.mc_basis  <= sel_vec(bus.req_basis, pick_idx);
                  bus.mc_result <= sel_vec(bus.req_result, pick_idx);
                  state         <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (bus.mc_ready) begin
                  if (bus.mc_is_zero) begin
                     ptr   <= next_ptr;
                     state <= S_IDLE;
                  end else begin
                     wdog  <= '0;
                     state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // back_setup is checked first so it wins a tie with the watchdog
               if (bus.req_back_setup[gidx]) begin
                  bus.mc_basis  <= sel_vec(bus.req_basis, gidx);
                  bus.mc_result <= sel_vec(bus.req_result, gidx);
                  state         <= S_BACK;
               end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                  ptr         <= next_ptr;
                  bus.timeout <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            default: begin
               if (bus.mc_ready) begin
                  ptr   <= next_ptr;
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_measure_arbiter.sv
// Directed bench for measure_arbiter: bench plays both requesters and the unit.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived constants per step.
module tb_measure_arbiter;

   localparam int NREQ = 4;
   localparam int BW   = 8;
   localparam int VW   = 3;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [BW-1:0] basis_v [NREQ];
   logic [BW-1:0] result_v [NREQ];

   measure_arbiter_if #(.NUM_REQ(NREQ), .BASIS_W(BW), .VALUE_W(VW)) bus ();

   measure_arbiter #(
      .NUM_REQ(NREQ), .NQ(4), .BASIS_W(BW), .VALUE_W(VW), .TIMEOUT(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_vecs();
      for (int k = 0; k < NREQ; k++) begin
         bus.req_basis[k*BW +: BW]  = basis_v[k];
         bus.req_result[k*BW +: BW] = result_v[k];
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.req_setup      = '0;
      bus.req_back_setup = '0;
      bus.mc_value       = '0;
      bus.mc_is_zero     = 1'b0;
      bus.mc_is_neg      = 1'b0;
      bus.mc_ready       = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         basis_v[k]  = 8'hA0 + 8'(k);
         result_v[k] = 8'h50 + 8'(k);
      end
      load_vecs();

      // reset state
      tick();
      tick();
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_setup", 32'(bus.mc_setup), 0);
      chk("rst_back", 32'(bus.mc_back_setup), 0);
      chk("rst_timeout", 32'(bus.timeout), 0);
      chk("rst_basis", 32'(bus.mc_basis), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      rst_n = 1'b1;
      tick();

      // single requester, zero result
      bus.req_setup = 4'b0001;
      tick();
      chk("t1_grant", 32'(bus.grant), 32'h1);
      chk("t1_setup", 32'(bus.mc_setup), 1);
      chk("t1_basis", 32'(bus.mc_basis), 32'hA0);
      chk("t1_result", 32'(bus.mc_result), 32'h50);
      tick();
      tick();
      chk("t1_noready_early", 32'(bus.req_ready), 0);
      bus.mc_ready   = 1'b1;
      bus.mc_is_zero = 1'b1;
      #1;
      chk("t1_ready", 32'(bus.req_ready), 32'h1);
      chk("t1_is_zero", 32'(bus.is_zero), 1);
      tick();
      bus.mc_ready   = 1'b0;
      bus.mc_is_zero = 1'b0;
      bus.req_setup  = '0;
      #1;
      chk("t1_grant_clr", 32'(bus.grant), 0);
      chk("t1_setup_drop", 32'(bus.mc_setup), 0);
      chk("t1_no_back", 32'(bus.mc_back_setup), 0);

      // full transaction by req2 (ptr now 1)
      bus.req_setup = 4'b0100;
      tick();
      chk("t2_grant", 32'(bus.grant), 32'h4);
      chk("t2_basis", 32'(bus.mc_basis), 32'hA2);
      bus.mc_ready = 1'b1;
      bus.mc_value = 3'b101;
      #1;
      chk("t2_ready1", 32'(bus.req_ready), 32'h4);
      chk("t2_value", 32'(bus.value), 32'h5);
      tick();
      bus.mc_ready  = 1'b0;
      bus.req_setup = '0;
      #1;
      chk("t2_hold_setup", 32'(bus.mc_setup), 0);
      chk("t2_hold_grant", 32'(bus.grant), 32'h4);
      chk("t2_hold_ready", 32'(bus.req_ready), 0);
      // non-owner back_setup ignored
      bus.req_back_setup = 4'b0010;
      tick();
      chk("t2_nonowner", 32'(bus.mc_back_setup), 0);
      basis_v[2] = 8'hC2;
      load_vecs();
      bus.req_back_setup = 4'b0100;
      tick();
      chk("t2_back", 32'(bus.mc_back_setup), 1);
      chk("t2_recapture", 32'(bus.mc_basis), 32'hC2);
      bus.mc_ready  = 1'b1;
      bus.mc_is_neg = 1'b1;
      #1;
      chk("t2_ready2", 32'(bus.req_ready), 32'h4);
      chk("t2_is_neg", 32'(bus.is_neg), 1);
      tick();
      bus.mc_ready       = 1'b0;
      bus.mc_is_neg      = 1'b0;
      bus.mc_value       = '0;
      bus.req_back_setup = '0;
      #1;
      chk("t2_release", 32'(bus.grant), 0);
      chk("t2_back_drop", 32'(bus.mc_back_setup), 0);
      // ptr should be 3: req3 wins among all
      bus.req_setup = 4'b1111;
      tick();
      chk("t2_ptr3", 32'(bus.grant), 32'h8);
      chk("t2_ptr3_basis", 32'(bus.mc_basis), 32'hA3);
      bus.mc_ready   = 1'b1;
      bus.mc_is_zero = 1'b1;
      tick();
      bus.mc_ready   = 1'b0;
      bus.mc_is_zero = 1'b0;
      bus.req_setup  = '0;

      // watchdog: req1 never asks for back_setup (ptr now 0)
      bus.req_setup = 4'b0010;
      tick();
      chk("wd_grant", 32'(bus.grant), 32'h2);
      bus.mc_ready = 1'b1;
      tick();
      bus.mc_ready  = 1'b0;
      bus.req_setup = 4'b0101;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("wd_hold_to", 32'(bus.timeout), 0);
         chk("wd_hold_grant", 32'(bus.grant), 32'h2);
         tick();
      end
      chk("wd_pulse", 32'(bus.timeout), 1);
      chk("wd_grant_clr", 32'(bus.grant), 0);
      tick();
      chk("wd_pulse_end", 32'(bus.timeout), 0);
      chk("wd_next", 32'(bus.grant), 32'h4);
      bus.req_setup = '0;

      // tie: owner back_setup on the final watchdog cycle
      bus.mc_ready = 1'b1;
      tick();
      bus.mc_ready = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      bus.req_back_setup = 4'b0100;
      tick();
      chk("tie_back", 32'(bus.mc_back_setup), 1);
      chk("tie_no_to", 32'(bus.timeout), 0);
      chk("tie_grant", 32'(bus.grant), 32'h4);

      // reset during S_BACK
      rst_n        = 1'b0;
      bus.mc_ready = 1'b1;
      tick();
      chk("rb_grant", 32'(bus.grant), 0);
      chk("rb_back", 32'(bus.mc_back_setup), 0);
      chk("rb_ready", 32'(bus.req_ready), 0);
      chk("rb_basis", 32'(bus.mc_basis), 0);
      bus.mc_ready       = 1'b0;
      bus.req_back_setup = '0;
      rst_n              = 1'b1;

      // contention from reset: order 0,1,2,3
      bus.req_setup = 4'b1111;
      for (int k = 0; k < NREQ; k++) begin
         tick();
         chk("ct_grant", 32'(bus.grant), 32'(1) << k);
         chk("ct_basis", 32'(bus.mc_basis), 32'(basis_v[k]));
         bus.mc_ready   = 1'b1;
         bus.mc_is_zero = 1'b1;
         #1;
         chk("ct_ready", 32'(bus.req_ready), 32'(1) << k);
         tick();
         bus.mc_ready   = 1'b0;
         bus.mc_is_zero = 1'b0;
         #1;
         chk("ct_gap", 32'(bus.grant), 0);
      end
      bus.req_setup = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
